// File: rtl/pipe_ctrl.sv
// Hazard/stall sequencer for the 5-stage LC-3b pipeline: stage-latch enables,
// latch valid bits, PC load/redirect, plus saturating stall and flush counters.
module pipe_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              icache_resp,
  input  logic              dcache_req,
  input  logic              dcache_resp,
  input  logic              dep_stall,
  input  logic              br_redirect,
  input  logic [ADDR_W-1:0] target_in,
  output logic              load_pc,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              load_de,
  output logic              load_ex,
  output logic              load_mem,
  output logic              load_wb,
  output logic              valid_de_in,
  output logic              valid_ex_in,
  output logic              valid_mem_in,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]    stall_q, stall_d, flush_q, flush_d;
  logic                fstall_s, bstall_s, stall_inc_s, flush_inc_s;

  // Next-state and combinational stage controls; everything stays 0 while in reset.
  always_comb begin
    fstall_s     = fetch_req & ~icache_resp;
    bstall_s     = dcache_req & ~dcache_resp;
    state_d      = state_q;
    target_d     = target_q;
    flush_inc_s  = 1'b0;
    load_pc      = 1'b0;
    pc_redirect  = 1'b0;
    load_de      = 1'b0;
    load_ex      = 1'b0;
    load_mem     = 1'b0;
    load_wb      = 1'b0;
    valid_de_in  = 1'b0;
    valid_ex_in  = 1'b0;
    valid_mem_in = 1'b0;
    redirect_pc  = (state_q == DRAIN) ? target_q : target_in;

    if (!rst_n) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bstall_s) begin
            state_d = RUN;
          end else if (br_redirect && fstall_s) begin
            // Squash the pipe now, but steer the PC only once the stale fetch returns.
            load_de     = 1'b1;
            load_ex     = 1'b1;
            load_mem    = 1'b1;
            load_wb     = 1'b1;
            target_d    = target_in;
            flush_inc_s = 1'b1;
            state_d     = DRAIN;
          end else if (br_redirect) begin
            load_pc     = 1'b1;
            pc_redirect = 1'b1;
            load_de     = 1'b1;
            load_ex     = 1'b1;
            load_mem    = 1'b1;
            load_wb     = 1'b1;
            flush_inc_s = 1'b1;
          end else if (fstall_s) begin
            state_d = RUN;
          end else if (dep_stall) begin
            load_ex      = 1'b1;
            load_mem     = 1'b1;
            load_wb      = 1'b1;
            valid_mem_in = 1'b1;
          end else begin
            load_pc      = 1'b1;
            load_de      = 1'b1;
            load_ex      = 1'b1;
            load_mem     = 1'b1;
            load_wb      = 1'b1;
            valid_de_in  = 1'b1;
            valid_ex_in  = 1'b1;
            valid_mem_in = 1'b1;
          end
        end
        DRAIN: begin
          if (!bstall_s) begin
            load_ex  = 1'b1;
            load_mem = 1'b1;
            load_wb  = 1'b1;
          end else begin
            load_ex  = 1'b0;
          end
          if (icache_resp) begin
            load_de     = 1'b1;
            load_pc     = 1'b1;
            pc_redirect = 1'b1;
            state_d     = RUN;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    stall_inc_s = rst_n & (~load_de | ((state_q == DRAIN) & ~valid_de_in));
    if (stall_inc_s && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
    if (flush_inc_s && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_d = flush_q;
    end
  end

  // State, pending redirect target and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      target_q <= {ADDR_W{1'b0}};
      stall_q  <= {CNT_W{1'b0}};
      flush_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

  // A second redirect cannot arrive while the first is still waiting on the i-cache.
  drain_no_redirect_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DRAIN) |-> !br_redirect);

endmodule
